// File: rtl/voice_allocator_pkg.sv
// Shared constants, types and helpers for the polyphonic voice allocator.
package voice_allocator_pkg;

    localparam int unsigned NUM_VOICES_DEF = 4;
    localparam int unsigned KEY_W_DEF      = 7;
    localparam int unsigned KEY_NONE       = 0;
    localparam int unsigned KEY_MAX        = 88;
    localparam int unsigned KEY_A4         = 49;

    typedef logic [KEY_W_DEF-1:0] key_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_t;

    // A key is playable when it is neither silence nor beyond the top of the keyboard.
    function automatic logic key_valid(input logic [31:0] key);
        return (key != 32'(KEY_NONE)) && (key <= 32'(KEY_MAX));
    endfunction

endpackage

// File: rtl/voice_lru.sv
// Rank array for voice ages: rank 0 is newest, rank NUM_VOICES-1 is the steal victim.
module voice_lru
    import voice_allocator_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter int unsigned IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch,
    input  logic [IDX_W-1:0] touch_idx,
    output logic [IDX_W-1:0] oldest
);

    logic [IDX_W-1:0] rank [NUM_VOICES];

    // Touched voice becomes newest; everything younger than it ages by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                rank[i] <= IDX_W'(i);
            end
        end else if (touch) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                if (IDX_W'(i) == touch_idx) begin
                    rank[i] <= '0;
                end else if (rank[i] < rank[touch_idx]) begin
                    rank[i] <= rank[i] + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        oldest = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (rank[i] == IDX_W'(NUM_VOICES - 1)) begin
                oldest = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Assigns note-on/off events to oscillator voices, stealing the least-recently-assigned voice when full.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter int unsigned KEY_W      = KEY_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [KEY_W-1:0]             ev_key,
    output logic [NUM_VOICES*KEY_W-1:0]  voice_key,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic                         steal
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    state_t           state;
    state_t           next_state;
    logic             lat_on;
    logic [KEY_W-1:0] lat_key;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] match_idx;
    logic [IDX_W-1:0] free_idx;
    logic             match_found;
    logic             free_found;

    logic             accept_c;
    logic             touch_c;
    logic             steal_c;
    logic [IDX_W-1:0] slot_c;
    logic [IDX_W-1:0] oldest_c;

    assign ev_ready = (state == ST_IDLE);
    assign accept_c = ev_valid && (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Out-of-range keys are consumed in IDLE without starting a scan.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept_c && key_valid(32'(ev_key))) next_state = ST_SCAN;
            ST_SCAN:   if (idx == LAST_IDX) next_state = ST_COMMIT;
            ST_COMMIT: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Note-on target: retrigger a match, else fill a free voice, else steal the oldest.
    always_comb begin
        touch_c = 1'b0;
        steal_c = 1'b0;
        slot_c  = oldest_c;
        if (state == ST_COMMIT && lat_on) begin
            touch_c = 1'b1;
            if (match_found) begin
                slot_c = match_idx;
            end else if (free_found) begin
                slot_c = free_idx;
            end else begin
                steal_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_on       <= 1'b0;
            lat_key      <= '0;
            idx          <= '0;
            match_idx    <= '0;
            free_idx     <= '0;
            match_found  <= 1'b0;
            free_found   <= 1'b0;
            voice_key    <= '0;
            voice_active <= '0;
            voice_trig   <= '0;
            steal        <= 1'b0;
        end else begin
            voice_trig <= '0;
            steal      <= 1'b0;
            if (accept_c) begin
                lat_on      <= ev_on;
                lat_key     <= ev_key;
                idx         <= '0;
                match_found <= 1'b0;
                free_found  <= 1'b0;
            end
            if (state == ST_SCAN) begin
                idx <= idx + IDX_W'(1);
                if (!match_found && voice_active[idx] &&
                    voice_key[idx*KEY_W +: KEY_W] == lat_key) begin
                    match_found <= 1'b1;
                    match_idx   <= idx;
                end
                if (!free_found && !voice_active[idx]) begin
                    free_found <= 1'b1;
                    free_idx   <= idx;
                end
            end
            if (state == ST_COMMIT) begin
                if (lat_on) begin
                    voice_key[slot_c*KEY_W +: KEY_W] <= lat_key;
                    voice_active[slot_c]             <= 1'b1;
                    voice_trig[slot_c]               <= 1'b1;
                    steal                            <= steal_c;
                end else if (match_found) begin
                    voice_key[match_idx*KEY_W +: KEY_W] <= '0;
                    voice_active[match_idx]             <= 1'b0;
                end
            end
        end
    end

    voice_lru #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .touch     (touch_c),
        .touch_idx (slot_c),
        .oldest    (oldest_c)
    );

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with NUM_VOICES=4: fill, steal, retrigger, note-off, drop and reset.
module tb_voice_allocator;

    logic        clk;
    logic        rst;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_on;
    logic [6:0]  ev_key;
    logic [27:0] voice_key;
    logic [3:0]  voice_active;
    logic [3:0]  voice_trig;
    logic        steal;

    int vectors;
    int miscompares;

    voice_allocator #(.NUM_VOICES(4), .KEY_W(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_on        (ev_on),
        .ev_key       (ev_key),
        .voice_key    (voice_key),
        .voice_active (voice_active),
        .voice_trig   (voice_trig),
        .steal        (steal)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [27:0] pk(input int k0, input int k1, input int k2, input int k3);
        return {7'(k3), 7'(k2), 7'(k1), 7'(k0)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one event and check the full accept -> scan -> commit timeline.
    task automatic apply(input string tag, input logic on, input logic [6:0] key, input logic dropped,
                         input logic [3:0] exp_trig, input logic exp_steal,
                         input logic [27:0] exp_key, input logic [3:0] exp_act);
        int guard;
        guard = 0;
        while (!ev_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk({tag, "_ready_timeout"}, 64'(ev_ready), 64'd1);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_key   = key;
        step();
        ev_valid = 1'b0;
        if (dropped) begin
            chk({tag, "_ready"}, 64'(ev_ready), 64'd1);
            for (int e = 1; e <= 5; e++) begin
                step();
                chk({tag, "_trig_quiet"}, 64'(voice_trig), 64'd0);
            end
            chk({tag, "_key"}, 64'(voice_key), 64'(exp_key));
            chk({tag, "_active"}, 64'(voice_active), 64'(exp_act));
        end else begin
            chk({tag, "_ready_low"}, 64'(ev_ready), 64'd0);
            for (int e = 1; e <= 4; e++) begin
                step();
                chk({tag, "_trig_early"}, 64'(voice_trig), 64'd0);
                chk({tag, "_ready_busy"}, 64'(ev_ready), 64'd0);
            end
            step();
            chk({tag, "_trig"}, 64'(voice_trig), 64'(exp_trig));
            chk({tag, "_steal"}, 64'(steal), 64'(exp_steal));
            chk({tag, "_key"}, 64'(voice_key), 64'(exp_key));
            chk({tag, "_active"}, 64'(voice_active), 64'(exp_act));
            chk({tag, "_ready_back"}, 64'(ev_ready), 64'd1);
            step();
            chk({tag, "_trig_end"}, 64'(voice_trig), 64'd0);
            chk({tag, "_steal_end"}, 64'(steal), 64'd0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        ev_valid    = 1'b0;
        ev_on       = 1'b0;
        ev_key      = '0;

        repeat (3) step();
        chk("reset_key", 64'(voice_key), 64'd0);
        chk("reset_active", 64'(voice_active), 64'd0);
        chk("reset_trig", 64'(voice_trig), 64'd0);
        chk("reset_steal", 64'(steal), 64'd0);
        chk("reset_ready", 64'(ev_ready), 64'd1);
        rst = 1'b0;
        step();

        apply("fill49", 1'b1, 7'd49, 1'b0, 4'b0001, 1'b0, pk(49, 0, 0, 0), 4'b0001);
        apply("fill52", 1'b1, 7'd52, 1'b0, 4'b0010, 1'b0, pk(49, 52, 0, 0), 4'b0011);
        apply("fill56", 1'b1, 7'd56, 1'b0, 4'b0100, 1'b0, pk(49, 52, 56, 0), 4'b0111);
        apply("fill61", 1'b1, 7'd61, 1'b0, 4'b1000, 1'b0, pk(49, 52, 56, 61), 4'b1111);
        apply("steal64", 1'b1, 7'd64, 1'b0, 4'b0001, 1'b1, pk(64, 52, 56, 61), 4'b1111);
        apply("retrig52", 1'b1, 7'd52, 1'b0, 4'b0010, 1'b0, pk(64, 52, 56, 61), 4'b1111);
        apply("steal70", 1'b1, 7'd70, 1'b0, 4'b0100, 1'b1, pk(64, 52, 70, 61), 4'b1111);
        apply("off61", 1'b0, 7'd61, 1'b0, 4'b0000, 1'b0, pk(64, 52, 70, 0), 4'b0111);
        apply("on30", 1'b1, 7'd30, 1'b0, 4'b1000, 1'b0, pk(64, 52, 70, 30), 4'b1111);
        apply("off77", 1'b0, 7'd77, 1'b0, 4'b0000, 1'b0, pk(64, 52, 70, 30), 4'b1111);
        apply("on_key0", 1'b1, 7'd0, 1'b1, 4'b0000, 1'b0, pk(64, 52, 70, 30), 4'b1111);
        apply("on_key89", 1'b1, 7'd89, 1'b1, 4'b0000, 1'b0, pk(64, 52, 70, 30), 4'b1111);
        apply("steal88", 1'b1, 7'd88, 1'b0, 4'b0001, 1'b1, pk(88, 52, 70, 30), 4'b1111);

        // Reset two cycles into the scan of a note-on.
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_key   = 7'd40;
        step();
        ev_valid = 1'b0;
        chk("midrst_accepted", 64'(ev_ready), 64'd0);
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("midrst_key", 64'(voice_key), 64'd0);
        chk("midrst_active", 64'(voice_active), 64'd0);
        chk("midrst_steal", 64'(steal), 64'd0);
        step();
        chk("midrst_ready", 64'(ev_ready), 64'd1);
        for (int e = 0; e < 5; e++) begin
            chk("midrst_no_trig", 64'(voice_trig), 64'd0);
            step();
        end

        apply("post_rst49", 1'b1, 7'd49, 1'b0, 4'b0001, 1'b0, pk(49, 0, 0, 0), 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
